// File: rtl/z_mips_pkg.sv
// Shared MIPS-subset encodings, instruction field positions and the
// decode helper used by the instruction decode / operand issue stage.
package z_mips_pkg;

    localparam int DATA_W = 32;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;

    // Instruction field positions
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int FN_HI    = 5;
    localparam int FN_LO    = 0;

    // Source selection for the A operand
    typedef enum logic {
        A_RS = 1'b0,
        A_RT = 1'b1
    } a_sel_e;

    // Source selection for the B operand
    typedef enum logic [1:0] {
        B_RT   = 2'd0,
        B_SEXT = 2'd1,
        B_ZEXT = 2'd2
    } b_sel_e;

    // Everything the stage needs to know about one instruction word
    typedef struct packed {
        logic       legal;
        logic       use_rs;
        logic       use_rt;
        logic       dest_en;
        logic [4:0] dest;
        a_sel_e     a_sel;
        b_sel_e     b_sel;
    } decode_t;

    // Classify an instruction word; unsupported encodings come back with
    // legal=0 and no source/destination use so they never stall or
    // touch the scoreboard.
    function automatic decode_t decode_ins(input logic [31:0] ins);
        decode_t    d;
        logic       has_dest;
        logic [5:0] op;
        logic [5:0] fn;
        op         = ins[OP_HI:OP_LO];
        fn         = ins[FN_HI:FN_LO];
        d          = '0;
        d.a_sel    = A_RS;
        d.b_sel    = B_RT;
        has_dest   = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU, FN_SUBU, FN_NOR: begin
                        d.legal  = 1'b1;
                        d.use_rs = 1'b1;
                        d.use_rt = 1'b1;
                        d.dest   = ins[RD_HI:RD_LO];
                        has_dest = 1'b1;
                    end
                    FN_SLL, FN_SRL: begin
                        d.legal  = 1'b1;
                        d.use_rt = 1'b1;
                        d.a_sel  = A_RT;
                        d.dest   = ins[RD_HI:RD_LO];
                        has_dest = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDIU, OP_LW: begin
                d.legal  = 1'b1;
                d.use_rs = 1'b1;
                d.b_sel  = B_SEXT;
                d.dest   = ins[RT_HI:RT_LO];
                has_dest = 1'b1;
            end
            OP_ANDI: begin
                d.legal  = 1'b1;
                d.use_rs = 1'b1;
                d.b_sel  = B_ZEXT;
                d.dest   = ins[RT_HI:RT_LO];
                has_dest = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                d.legal  = 1'b1;
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
            end
            OP_SW: begin
                d.legal  = 1'b1;
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
                d.b_sel  = B_SEXT;
            end
            default: ;
        endcase
        d.dest_en = has_dest && (d.dest != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/z_regfile.sv
// 32-entry register file with two read ports, one write port, a
// hard-wired zero in R0 and same-cycle write-to-read bypass.
module z_regfile
    import z_mips_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [4:0]   rd_addr_a,
    output logic [W-1:0] rd_data_a,
    input  logic [4:0]   rd_addr_b,
    output logic [W-1:0] rd_data_b,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [W-1:0] wr_data
);

    logic [W-1:0] mem [32];

    // Storage: cleared on reset, written on the clock edge, R0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port A: R0 reads zero, a concurrent write is forwarded
    always_comb begin
        rd_data_a = mem[rd_addr_a];
        if (rd_addr_a == 5'd0) begin
            rd_data_a = '0;
        end else if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    // Read port B: same behaviour as port A
    always_comb begin
        rd_data_b = mem[rd_addr_b];
        if (rd_addr_b == 5'd0) begin
            rd_data_b = '0;
        end else if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/z_id_stage.sv
// Instruction decode / operand issue stage feeding z_ALU: decodes one
// instruction per cycle, reads operands, tracks in-flight destinations
// in a pending scoreboard and stalls on read-after-write hazards.
module z_id_stage
    import z_mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_valid_in,
    input  logic [31:0]       ins_in,
    output logic              ins_ready,
    input  logic              ex_ready_in,
    input  logic              wb_en_in,
    input  logic [4:0]        wb_addr_in,
    input  logic [DATA_W-1:0] wb_data_in,
    output logic              alu_valid_out,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [4:0]        shamt_out,
    output logic [31:0]       ins_out,
    output logic [DATA_W-1:0] rt_data_out,
    output logic [4:0]        dest_out,
    output logic              dest_en_out,
    output logic              illegal_out
);

    decode_t           dec;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;
    logic [31:0]       pending;
    logic [31:0]       pending_next;
    logic              hazard_rs;
    logic              hazard_rt;
    logic              hazard;
    logic              accept;
    logic              issue;

    assign dec = decode_ins(ins_in);
    assign rs  = ins_in[RS_HI:RS_LO];
    assign rt  = ins_in[RT_HI:RT_LO];

    z_regfile #(
        .W(DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rs),
        .rd_data_a (rs_data),
        .rd_addr_b (rt),
        .rd_data_b (rt_data),
        .wr_en     (wb_en_in),
        .wr_addr   (wb_addr_in),
        .wr_data   (wb_data_in)
    );

    // Hazard check and handshake: a pending source only stalls if the
    // writeback port is not delivering that very register this cycle.
    always_comb begin
        hazard_rs = dec.use_rs && pending[rs] && !(wb_en_in && (wb_addr_in == rs));
        hazard_rt = dec.use_rt && pending[rt] && !(wb_en_in && (wb_addr_in == rt));
        hazard    = hazard_rs || hazard_rt;
        ins_ready = (!alu_valid_out || ex_ready_in) && !hazard;
        accept    = ins_valid_in && ins_ready;
        issue     = accept && dec.legal;
    end

    // Operand formation for the ALU
    always_comb begin
        a_next = (dec.a_sel == A_RT) ? rt_data : rs_data;
        case (dec.b_sel)
            B_SEXT:  b_next = {{(DATA_W-16){ins_in[IMM_HI]}}, ins_in[IMM_HI:IMM_LO]};
            B_ZEXT:  b_next = {{(DATA_W-16){1'b0}}, ins_in[IMM_HI:IMM_LO]};
            default: b_next = rt_data;
        endcase
    end

    // Scoreboard update: writeback clears first, issue sets afterwards so
    // a set and clear of the same register leaves it pending.
    always_comb begin
        pending_next = pending;
        if (wb_en_in) begin
            pending_next[wb_addr_in] = 1'b0;
        end
        if (issue && dec.dest_en) begin
            pending_next[dec.dest] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Output register: load on issue, drain when the ALU takes it, and
    // otherwise hold every field stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_valid_out <= 1'b0;
            a_out         <= '0;
            b_out         <= '0;
            shamt_out     <= '0;
            ins_out       <= '0;
            rt_data_out   <= '0;
            dest_out      <= '0;
            dest_en_out   <= 1'b0;
            illegal_out   <= 1'b0;
        end else begin
            illegal_out <= accept && !dec.legal;
            if (issue) begin
                alu_valid_out <= 1'b1;
                a_out         <= a_next;
                b_out         <= b_next;
                shamt_out     <= ins_in[SHAMT_HI:SHAMT_LO];
                ins_out       <= ins_in;
                rt_data_out   <= rt_data;
                dest_out      <= dec.dest;
                dest_en_out   <= dec.dest_en;
            end else if (ex_ready_in) begin
                alu_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_z_id_stage.sv
// Self-checking bench for z_id_stage: a reference model predicts the
// handshake each cycle and queues expected output-register contents for
// every accepted instruction, compared when the ALU consumes them.
module tb_z_id_stage;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;

    logic        clk;
    logic        rst_n;
    logic        ins_valid_in;
    logic [31:0] ins_in;
    logic        ins_ready;
    logic        ex_ready_in;
    logic        wb_en_in;
    logic [4:0]  wb_addr_in;
    logic [31:0] wb_data_in;
    logic        alu_valid_out;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [4:0]  shamt_out;
    logic [31:0] ins_out;
    logic [31:0] rt_data_out;
    logic [4:0]  dest_out;
    logic        dest_en_out;
    logic        illegal_out;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [31:0] ins;
        logic [31:0] rt;
        logic [4:0]  dest;
        logic        den;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_rf [32];
    logic [31:0] m_pend;
    logic        m_valid;
    logic        m_illegal;

    z_id_stage #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ins_valid_in  (ins_valid_in),
        .ins_in        (ins_in),
        .ins_ready     (ins_ready),
        .ex_ready_in   (ex_ready_in),
        .wb_en_in      (wb_en_in),
        .wb_addr_in    (wb_addr_in),
        .wb_data_in    (wb_data_in),
        .alu_valid_out (alu_valid_out),
        .a_out         (a_out),
        .b_out         (b_out),
        .shamt_out     (shamt_out),
        .ins_out       (ins_out),
        .rt_data_out   (rt_data_out),
        .dest_out      (dest_out),
        .dest_en_out   (dest_en_out),
        .illegal_out   (illegal_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {OP_R, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Model register read including R0 and writeback bypass
    function automatic logic [31:0] m_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
        if (wb_en_in && wb_addr_in == addr) return wb_data_in;
        return m_rf[addr];
    endfunction

    // Reference decode of the current instruction word
    task automatic m_decode(input logic [31:0] ins, output logic legal, output logic urs,
                            output logic urt, output logic den, output logic [4:0] dst,
                            output logic [31:0] a, output logic [31:0] b);
        logic [4:0]  rs = ins[25:21];
        logic [4:0]  rt = ins[20:16];
        logic [15:0] imm = ins[15:0];
        legal = 0; urs = 0; urt = 0; den = 0; dst = 0; a = 0; b = 0;
        if (ins[31:26] == OP_R) begin
            if (ins[5:0] inside {FN_ADDU, FN_SUBU, FN_NOR}) begin
                legal = 1; urs = 1; urt = 1; dst = ins[15:11]; den = 1;
                a = m_read(rs); b = m_read(rt);
            end else if (ins[5:0] inside {FN_SLL, FN_SRL}) begin
                legal = 1; urt = 1; dst = ins[15:11]; den = 1;
                a = m_read(rt); b = m_read(rt);
            end
        end else if (ins[31:26] inside {OP_ADDIU, OP_LW}) begin
            legal = 1; urs = 1; dst = rt; den = 1;
            a = m_read(rs); b = {{16{imm[15]}}, imm};
        end else if (ins[31:26] == OP_ANDI) begin
            legal = 1; urs = 1; dst = rt; den = 1;
            a = m_read(rs); b = {16'h0, imm};
        end else if (ins[31:26] inside {OP_BEQ, 6'b000101}) begin
            legal = 1; urs = 1; urt = 1;
            a = m_read(rs); b = m_read(rt);
        end else if (ins[31:26] == OP_SW) begin
            legal = 1; urs = 1; urt = 1;
            a = m_read(rs); b = {{16{imm[15]}}, imm};
        end
        if (dst == 5'd0) den = 0;
    endtask

    // Per-cycle model: check handshake, consume outputs, predict next state
    always @(negedge clk) begin
        logic        legal, urs, urt, den, hz, exp_ready, acc;
        logic [4:0]  dst;
        logic [31:0] ea, eb;
        exp_t        e;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
            m_pend    = 32'h0;
            m_valid   = 1'b0;
            m_illegal = 1'b0;
            exp_q.delete();
        end else begin
            m_decode(ins_in, legal, urs, urt, den, dst, ea, eb);
            hz = (urs && m_pend[ins_in[25:21]] && !(wb_en_in && wb_addr_in == ins_in[25:21])) ||
                 (urt && m_pend[ins_in[20:16]] && !(wb_en_in && wb_addr_in == ins_in[20:16]));
            exp_ready = (!m_valid || ex_ready_in) && !hz;
            checkOutput("ins_ready", {31'h0, ins_ready}, {31'h0, exp_ready});
            checkOutput("alu_valid_out", {31'h0, alu_valid_out}, {31'h0, m_valid});
            checkOutput("illegal_out", {31'h0, illegal_out}, {31'h0, m_illegal});
            if (m_valid && ex_ready_in) begin
                if (exp_q.size() == 0) begin
                    checkOutput("scoreboard_empty", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("a_out", a_out, e.a);
                    checkOutput("b_out", b_out, e.b);
                    checkOutput("shamt_out", {27'h0, shamt_out}, {27'h0, e.shamt});
                    checkOutput("ins_out", ins_out, e.ins);
                    checkOutput("rt_data_out", rt_data_out, e.rt);
                    checkOutput("dest_out", {27'h0, dest_out}, {27'h0, e.dest});
                    checkOutput("dest_en_out", {31'h0, dest_en_out}, {31'h0, e.den});
                end
            end
            acc       = ins_valid_in && exp_ready;
            m_illegal = acc && !legal;
            if (acc && legal) begin
                e.a = ea; e.b = eb; e.shamt = ins_in[10:6]; e.ins = ins_in;
                e.rt = m_read(ins_in[20:16]); e.dest = dst; e.den = den;
                exp_q.push_back(e);
                m_valid = 1'b1;
            end else if (ex_ready_in) begin
                m_valid = 1'b0;
            end
            if (wb_en_in) m_pend[wb_addr_in] = 1'b0;
            if (acc && legal && den) m_pend[dst] = 1'b1;
            m_pend[0] = 1'b0;
            if (wb_en_in && wb_addr_in != 5'd0) m_rf[wb_addr_in] = wb_data_in;
        end
    end

    // Drive one cycle of inputs and return just after the clock edge
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic ex,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
        ins_valid_in = v;
        ins_in       = ins;
        ex_ready_in  = ex;
        wb_en_in     = we;
        wb_addr_in   = wa;
        wb_data_in   = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, {31'h0, alu_valid_out}, 32'h0);
        checkOutput({tag, "_a"}, a_out, 32'h0);
        checkOutput({tag, "_b"}, b_out, 32'h0);
        checkOutput({tag, "_ins"}, ins_out, 32'h0);
        checkOutput({tag, "_rt"}, rt_data_out, 32'h0);
        checkOutput({tag, "_dest"}, {26'h0, dest_en_out, dest_out}, 32'h0);
        checkOutput({tag, "_shamt_ill"}, {26'h0, illegal_out, shamt_out}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        ins_valid_in = 0; ins_in = 0; ex_ready_in = 1;
        wb_en_in = 0; wb_addr_in = 0; wb_data_in = 0;
        #2;
        checkAllZero("reset");
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Writeback operands
        applyStimulus(0, 0, 1, 1, 5'd1, 32'h0FB7AFF0);
        applyStimulus(0, 0, 1, 1, 5'd2, 32'hA00D0FF0);

        // addu R3,R1,R2 then dependent subu R5,R3,R1 stalls until R3 returns
        applyStimulus(1, rtype(1, 2, 3, 0, FN_ADDU), 1, 0, 0, 0);
        checkOutput("addu_a", a_out, 32'h0FB7AFF0);
        checkOutput("addu_b", b_out, 32'hA00D0FF0);
        checkOutput("addu_dest", {26'h0, dest_en_out, dest_out}, {26'h0, 1'b1, 5'd3});
        applyStimulus(1, rtype(3, 1, 5, 0, FN_SUBU), 1, 0, 0, 0);
        applyStimulus(1, rtype(3, 1, 5, 0, FN_SUBU), 1, 0, 0, 0);
        applyStimulus(1, rtype(3, 1, 5, 0, FN_SUBU), 1, 1, 5'd3, 32'hAFC4BFE0);
        checkOutput("subu_a_bypass", a_out, 32'hAFC4BFE0);
        applyStimulus(0, 0, 1, 1, 5'd5, 32'h11112222);

        // Immediate extension
        applyStimulus(1, itype(OP_ADDIU, 1, 4, 16'hFFFC), 1, 0, 0, 0);
        checkOutput("addiu_b", b_out, 32'hFFFFFFFC);
        applyStimulus(1, itype(OP_ANDI, 1, 4, 16'hFFFC), 1, 0, 0, 0);
        checkOutput("andi_b", b_out, 32'h0000FFFC);
        applyStimulus(0, 0, 1, 1, 5'd4, 32'h00000044);

        // Back-pressure: hold for three cycles, then release
        applyStimulus(1, rtype(1, 2, 6, 0, FN_ADDU), 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, rtype(1, 2, 7, 0, FN_NOR), 0, 0, 0, 0);
            checkOutput("hold_a", a_out, 32'h0FB7AFF0);
            checkOutput("hold_ins", ins_out, rtype(1, 2, 6, 0, FN_ADDU));
        end
        applyStimulus(1, rtype(1, 2, 7, 0, FN_NOR), 1, 0, 0, 0);
        checkOutput("release_ins", ins_out, rtype(1, 2, 7, 0, FN_NOR));
        applyStimulus(0, 0, 1, 1, 5'd6, 32'h66666666);
        applyStimulus(0, 0, 1, 1, 5'd7, 32'h77777777);

        // R0 is immune to writes and never stalls; store has no destination
        applyStimulus(0, 0, 1, 1, 5'd0, 32'hFFFFFFFF);
        applyStimulus(1, rtype(0, 0, 6, 0, FN_ADDU), 1, 0, 0, 0);
        checkOutput("r0_ab", a_out | b_out, 32'h0);
        applyStimulus(1, itype(OP_SW, 2, 1, 16'h0008), 1, 0, 0, 0);
        checkOutput("sw_rt_data", rt_data_out, 32'h0FB7AFF0);
        checkOutput("sw_dest_en", {31'h0, dest_en_out}, 32'h0);
        applyStimulus(0, 0, 1, 1, 5'd6, 32'h0);

        // Shifts, branch and load, back to back
        applyStimulus(1, rtype(0, 2, 10, 5'd4, FN_SLL), 1, 0, 0, 0);
        applyStimulus(1, rtype(0, 1, 11, 5'd31, FN_SRL), 1, 0, 0, 0);
        applyStimulus(1, itype(OP_BEQ, 1, 2, 16'h8001), 1, 0, 0, 0);
        applyStimulus(1, itype(OP_LW, 1, 9, 16'h0004), 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 5'd9, 32'h99999999);

        // Unsupported opcode and unsupported funct are dropped
        applyStimulus(1, 32'hFC000000, 1, 1, 5'd10, 32'h0);
        applyStimulus(1, rtype(1, 2, 12, 0, 6'b111111), 1, 1, 5'd11, 32'h0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);

        // Reset in the middle of a stall
        applyStimulus(1, rtype(1, 2, 8, 0, FN_ADDU), 1, 0, 0, 0);
        applyStimulus(1, rtype(8, 1, 9, 0, FN_SUBU), 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(1, rtype(1, 2, 8, 0, FN_ADDU), 1, 0, 0, 0);
        checkOutput("post_reset_a", a_out, 32'h0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("queue_drained", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/z_id_stage.md
# z_id_stage

Instruction decode / operand issue stage sitting directly upstream of `z_ALU`. It accepts one 32-bit MIPS-subset instruction per cycle, reads a 32x32 register file, forms the ALU operands (`a_in`, `b_in`, `shamt_in`, `ins_in`) in a registered output stage, and stalls on read-after-write hazards using a per-register pending scoreboard. Writeback from later stages enters through a dedicated write port.

## Interface
- `DATA_W`, 32: datapath width; only 32 is supported.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ins_valid_in` in 1: fetch presents a valid instruction.
- `ins_in` in 32: instruction word.
- `ins_ready` out 1: stage accepts `ins_in` this cycle.
- `ex_ready_in` in 1: ALU stage can take the output register contents.
- `wb_en_in` in 1, `wb_addr_in` in 5, `wb_data_in` in 32: register writeback port.
- `alu_valid_out` out 1: output register holds a valid instruction.
- `a_out`, `b_out` out 32: ALU operands (drive `z_ALU.a_in` / `b_in`).
- `shamt_out` out 5, `ins_out` out 32: drive `z_ALU.shamt_in` / `ins_in`.
- `rt_data_out` out 32: R[rt], store data for `sw`.
- `dest_out` out 5, `dest_en_out` out 1: writeback target of the issued instruction.
- `illegal_out` out 1: one-cycle pulse, unsupported opcode/funct dropped.

## Operation
- Supported: R-type (op 000000) funct addu 100001, subu 100011, nor 100111, sll 000000, srl 000010; addiu 001001, andi 001100, beq 000100, bne 000101, lw 100011, sw 101011.
- Operands: R-type arith: a=R[rs], b=R[rt]; sll/srl: a=R[rt], b=R[rt] (ALU shifts rt); addiu/lw/sw: a=R[rs], b=sign-ext imm16; andi: b=zero-ext imm16; beq/bne: b=R[rt]. `shamt_out`=ins[10:6]; `ins_out`=ins_in unmodified.
- Dest: R-type -> rd; addiu/andi/lw -> rt; beq/bne/sw -> none (`dest_en_out`=0). Dest 0 always yields `dest_en_out`=0.
- Sources: rs for all except sll/srl; rt for R-type, beq, bne, sw.
- Register file: R0 reads 0, writes to R0 ignored. Write at clock edge when `wb_en_in`. Same-cycle read of `wb_addr_in` returns `wb_data_in` (bypass).
- Scoreboard: 32 pending bits, bit 0 constant 0. Set for dest on issue; cleared on `wb_en_in` for `wb_addr_in`. Simultaneous set and clear of same register: set wins.
- Hazard: any used source pending and not being written this cycle by `wb_en_in`.
- `ins_ready` = (!`alu_valid_out` | `ex_ready_in`) & !hazard.
- Unsupported encoding: accepted when `ins_ready`, not issued, no scoreboard change, `illegal_out`=1 next cycle.

## Timing
- Reset: all outputs 0, register file all 0, scoreboard 0.
- Latency 1: instruction accepted at edge N appears on outputs after edge N with `alu_valid_out`=1.
- Output register holds all fields stable while `alu_valid_out` & !`ex_ready_in`.
- Drains (`alu_valid_out`->0) when `ex_ready_in` and no accept in same cycle.
- Stall: `ins_ready` low combinationally from `ins_in`; upstream holds `ins_in`. No bubble inserted beyond drain.
- Back-to-back independent instructions: one per cycle with `ex_ready_in` high.
- Reset mid-operation: output register, scoreboard and register file cleared immediately; in-flight instructions lost.

## Structure
- Package `z_mips_pkg`: opcode and funct constants above, field-slice localparams (rs 25:21, rt 20:16, rd 15:11, shamt 10:6, imm 15:0).
- Sub-module `z_regfile`: 32x32, 2 read / 1 write, R0 zero, write-to-read bypass, async active-low reset.
- Decode, scoreboard, handshake and output register in `z_id_stage`.

## Test plan
- Reset, then wb R1=0x0FB7AFF0, R2=0xA00D0FF0; issue addu R3,R1,R2 -> next cycle a_out=0x0FB7AFF0, b_out=0xA00D0FF0, dest_out=3, dest_en_out=1.
- addiu R4,R1,0xFFFC -> b_out=0xFFFFFFFC; andi R4,R1,0xFFFC -> b_out=0x0000FFFC.
- addu R3,R1,R2 then subu R5,R3,R1 with no wb -> ins_ready=0 held; wb R3=0xAFC4BFE0 -> same cycle ins_ready=1, next a_out=0xAFC4BFE0.
- ex_ready_in=0 for 3 cycles with valid output -> outputs unchanged, ins_ready=0; release -> next instruction issues following cycle.
- wb R0=0xFFFFFFFF, then addu R6,R0,R0 -> a_out=b_out=0, no stall; sw R1,8(R2) -> dest_en_out=0, rt_data_out=R[rt].
- ins_in op=111111 -> accepted, illegal_out pulses once, alu_valid_out stays 0; assert rst_n low mid-stall -> all outputs 0 asynchronously.
